// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM sampling read master: default bus widths,
// the read FSM state type and a small elaboration-time helper.
package sram_pkg;

    localparam int SRAM_ADDR_W = 15;
    localparam int SRAM_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        PRESENT,
        DONE
    } rd_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter used to time both the address setup and the strobe
// access phases; expired is high while the count sits at zero.
module sram_wait_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sram_read_master.sv
// Sweeps an inclusive (wrapping) address range over the SRAM sampling read bus
// and streams every (address, data) pair out on a valid/ready interface.
module sram_read_master
    import sram_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int SETUP_CYC  = 1,
    parameter int ACCESS_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_read,
    input  logic [DATA_W-1:0] sram_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam int TW = $clog2(max_int(SETUP_CYC, ACCESS_CYC) + 1);
    // The timer expires at zero, so loading N-1 keeps a phase for N cycles.
    localparam logic [TW-1:0] SETUP_LOAD  = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] ACCESS_LOAD = TW'(ACCESS_CYC - 1);

    rd_state_t         state;
    rd_state_t         state_next;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last;
    logic              timer_load;
    logic [TW-1:0]     timer_value;
    logic              timer_expired;
    logic              latch_range;
    logic              advance;
    logic              capture;

    sram_wait_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .value  (timer_value),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_value = SETUP_LOAD;
        latch_range = 1'b0;
        advance     = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = SETUP;
                    timer_load  = 1'b1;
                    latch_range = 1'b1;
                end
            end
            SETUP: begin
                if (timer_expired) begin
                    state_next  = ACCESS;
                    timer_load  = 1'b1;
                    timer_value = ACCESS_LOAD;
                end
            end
            ACCESS: begin
                if (timer_expired) begin
                    state_next = PRESENT;
                    capture    = 1'b1;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (cur == last) begin
                        state_next = DONE;
                    end else begin
                        state_next = SETUP;
                        timer_load = 1'b1;
                        advance    = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Abort wins over any handshake or sample in flight.
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            timer_load = 1'b0;
            advance    = 1'b0;
            capture    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= '0;
            last     <= '0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            if (latch_range) begin
                cur  <= start_addr;
                last <= end_addr;
            end else if (advance) begin
                cur <= cur + 1'b1;
            end
            if (capture) begin
                out_addr <= cur;
                out_data <= sram_data;
            end
        end
    end

    // Strobe and stream flags come straight from the state register, so the
    // address (held in cur) can never move while the strobe is high.
    assign sram_addr = cur;
    assign busy      = (state != IDLE);
    assign sram_read = (state == ACCESS);
    assign out_valid = (state == PRESENT);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_sram_read_master.sv
// Randomised self-checking bench for sram_read_master: an arithmetic sweep model
// predicts every sample and its timing; two extra instances cover other timings.
module tb_sram_read_master;

    localparam int P_SETUP  = 1;
    localparam int P_ACCESS = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        out_ready;
    logic [14:0] start_addr;
    logic [14:0] end_addr;

    logic        busy, done, sram_read, out_valid;
    logic [14:0] sram_addr, out_addr;
    logic [7:0]  sram_data, out_data;

    logic        fast_busy, fast_done, fast_read, fast_valid;
    logic [14:0] fast_sram_addr, fast_out_addr;
    logic [7:0]  fast_sram_data, fast_out_data;

    logic        slow_busy, slow_done, slow_read, slow_valid;
    logic [14:0] slow_sram_addr, slow_out_addr;
    logic [7:0]  slow_sram_data, slow_out_data;

    int checks = 0;
    int errors = 0;

    // SRAM contents: each word is the low address byte XOR 0xA5.
    assign sram_data      = sram_addr[7:0] ^ 8'hA5;
    assign fast_sram_data = fast_sram_addr[7:0] ^ 8'hA5;
    assign slow_sram_data = slow_sram_addr[7:0] ^ 8'hA5;

    sram_read_master #(.ADDR_W(15), .DATA_W(8), .SETUP_CYC(P_SETUP), .ACCESS_CYC(P_ACCESS)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr),
        .busy(busy), .done(done), .sram_addr(sram_addr), .sram_read(sram_read),
        .sram_data(sram_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data)
    );

    sram_read_master #(.ADDR_W(15), .DATA_W(8), .SETUP_CYC(1), .ACCESS_CYC(1)) u_dut_fast (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr),
        .busy(fast_busy), .done(fast_done), .sram_addr(fast_sram_addr), .sram_read(fast_read),
        .sram_data(fast_sram_data), .out_valid(fast_valid), .out_ready(out_ready),
        .out_addr(fast_out_addr), .out_data(fast_out_data)
    );

    sram_read_master #(.ADDR_W(15), .DATA_W(8), .SETUP_CYC(3), .ACCESS_CYC(7)) u_dut_slow (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_addr(start_addr), .end_addr(end_addr),
        .busy(slow_busy), .done(slow_done), .sram_addr(slow_sram_addr), .sram_read(slow_read),
        .sram_data(slow_sram_data), .out_valid(slow_valid), .out_ready(out_ready),
        .out_addr(slow_out_addr), .out_data(slow_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_data(input logic [14:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (sram_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_sram_read: got %b want 0", sram_read); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sram_addr !== 15'h0) begin errors++; $display("[TB] FAIL reset_sram_addr: got %h want 0", sram_addr); end
        checks++; if (out_addr !== 15'h0) begin errors++; $display("[TB] FAIL reset_out_addr: got %h want 0", out_addr); end
        checks++; if (out_data !== 8'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0", out_data); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Runs one full sweep on the main instance and checks every sample and timing rule.
    task automatic do_sweep(input string name, input logic [14:0] s, input logic [14:0] e,
                            input bit rand_ready, input bit poke_start);
        int          words;
        int          idx;
        int          rises;
        int          dones;
        int          cyc;
        int          last_rise;
        int          budget;
        logic        prev_read;
        logic        prev_valid;
        logic [14:0] prev_addr;
        logic [14:0] exp_addr;
        words  = ((int'(e) - int'(s)) & 32'h7FFF) + 1;
        budget = words * 60 + 60;
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_addr = 15'($urandom);
        end_addr   = 15'($urandom);
        idx = 0; rises = 0; dones = 0; cyc = 1; last_rise = 0;
        prev_read = 1'b0; prev_valid = 1'b0; prev_addr = sram_addr;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL %s busy_after_start: got %b want 1", name, busy); end
        while (dones == 0 && cyc < budget) begin
            if (sram_read && !prev_read) begin
                exp_addr = 15'(int'(s) + rises);
                checks++; if (sram_addr !== exp_addr) begin errors++; $display("[TB] FAIL %s strobe_addr: got %h want %h", name, sram_addr, exp_addr); end
                if (rises == 0) begin
                    checks++; if (cyc != 1 + P_SETUP) begin errors++; $display("[TB] FAIL %s first_strobe_cycle: got %0d want %0d", name, cyc, 1 + P_SETUP); end
                end else if (!rand_ready) begin
                    checks++; if (cyc - last_rise != P_SETUP + P_ACCESS + 1) begin errors++; $display("[TB] FAIL %s word_period: got %0d want %0d", name, cyc - last_rise, P_SETUP + P_ACCESS + 1); end
                end
                last_rise = cyc;
                rises++;
            end
            if (sram_read) begin
                checks++; if (sram_addr !== prev_addr) begin errors++; $display("[TB] FAIL %s addr_moved_in_strobe: got %h want %h", name, sram_addr, prev_addr); end
            end
            if (out_valid) begin
                exp_addr = 15'(int'(s) + idx);
                checks++; if (idx >= words || out_addr !== exp_addr || out_data !== model_data(exp_addr)) begin
                    errors++; $display("[TB] FAIL %s sample%0d: got (%h,%h) want (%h,%h)", name, idx, out_addr, out_data, exp_addr, model_data(exp_addr));
                end
                checks++; if (sram_read !== 1'b0) begin errors++; $display("[TB] FAIL %s strobe_in_present: got %b want 0", name, sram_read); end
                if (!prev_valid) begin
                    checks++; if (cyc != last_rise + P_ACCESS) begin errors++; $display("[TB] FAIL %s valid_rise_cycle: got %0d want %0d", name, cyc, last_rise + P_ACCESS); end
                end
            end
            if (done) begin
                dones++;
                checks++; if (idx != words) begin errors++; $display("[TB] FAIL %s words_before_done: got %0d want %0d", name, idx, words); end
                if (!rand_ready) begin
                    checks++; if (cyc != 1 + words * (P_SETUP + P_ACCESS + 1)) begin errors++; $display("[TB] FAIL %s done_cycle: got %0d want %0d", name, cyc, 1 + words * (P_SETUP + P_ACCESS + 1)); end
                end
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) idx++;
            start = (poke_start && cyc == 4);
            if (start) begin
                start_addr = 15'($urandom);
                end_addr   = 15'($urandom);
            end
            prev_read  = sram_read;
            prev_valid = out_valid;
            prev_addr  = sram_addr;
            @(posedge clk);
            #1;
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        checks++; if (dones != 1) begin errors++; $display("[TB] FAIL %s done_pulses: got %0d want 1 (cycle %0d)", name, dones, cyc); end
        checks++; if (rises != words) begin errors++; $display("[TB] FAIL %s strobe_count: got %0d want %0d", name, rises, words); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL %s idle_after_done: got busy=%b done=%b want 0 0", name, busy, done); end
    endtask

    task automatic test_basic;
        do_sweep("basic", 15'h0010, 15'h0013, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        do_sweep("stall", 15'h0010, 15'h0013, 1'b1, 1'b1);
    endtask

    task automatic test_wrap;
        do_sweep("wrap", 15'h7FFE, 15'h0001, 1'b0, 1'b0);
    endtask

    task automatic test_single;
        do_sweep("single", 15'h1234, 15'h1234, 1'b1, 1'b0);
    endtask

    task automatic test_abort;
        int   rises;
        int   cyc;
        int   dones;
        logic prev;
        out_ready  = 1'b1;
        start_addr = 15'h0200;
        end_addr   = 15'h0205;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rises = 0; cyc = 0; prev = 1'b0;
        while (rises < 2 && cyc < 100) begin
            if (sram_read && !prev) rises++;
            if (rises < 2) begin
                prev = sram_read;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        checks++; if (rises != 2) begin errors++; $display("[TB] FAIL abort_reach_word2: got %0d strobes want 2", rises); end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++; if (sram_read !== 1'b0) begin errors++; $display("[TB] FAIL abort_sram_read: got %b want 0", sram_read); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || sram_read) dones++;
            @(posedge clk);
            #1;
        end
        checks++; if (dones != 0) begin errors++; $display("[TB] FAIL abort_no_activity: got %0d active cycles want 0", dones); end
        do_sweep("restart", 15'h0300, 15'h0301, 1'b0, 1'b0);
    endtask

    task automatic test_reset_present;
        int cyc;
        out_ready  = 1'b0;
        start_addr = 15'h0400;
        end_addr   = 15'h0402;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_reach_present: got %b want 1", out_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({busy, done, sram_read, out_valid} !== 4'b0) begin errors++; $display("[TB] FAIL rst_flags: got %b want 0000", {busy, done, sram_read, out_valid}); end
        checks++; if (sram_addr !== 15'h0 || out_addr !== 15'h0) begin errors++; $display("[TB] FAIL rst_addrs: got %h %h want 0 0", sram_addr, out_addr); end
        checks++; if (out_data !== 8'h0) begin errors++; $display("[TB] FAIL rst_out_data: got %h want 0", out_data); end
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle: got busy=%b valid=%b want 0 0", busy, out_valid); end
        do_sweep("after_rst", 15'h0500, 15'h0501, 1'b0, 1'b0);
    endtask

    // Three instances with different setup/access timings swept side by side.
    task automatic test_timing_variants;
        int         sc[3] = '{1, 1, 3};
        int         ac[3] = '{4, 1, 7};
        int         first_rise[3];
        int         second_rise[3];
        int         first_valid[3];
        int         done_cyc[3];
        int         rises[3];
        logic [7:0] first_data[3];
        logic       rd[3];
        logic       vl[3];
        logic       dn[3];
        logic       prev_rd[3];
        logic       prev_vl[3];
        logic [7:0] od[3];
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            first_rise[k] = -1; second_rise[k] = -1; first_valid[k] = -1; done_cyc[k] = -1;
            rises[k] = 0; first_data[k] = 8'h0; prev_rd[k] = 1'b0; prev_vl[k] = 1'b0;
        end
        start_addr = 15'h0100;
        end_addr   = 15'h0102;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            rd = '{sram_read, fast_read, slow_read};
            vl = '{out_valid, fast_valid, slow_valid};
            dn = '{done, fast_done, slow_done};
            od = '{out_data, fast_out_data, slow_out_data};
            for (int k = 0; k < 3; k++) begin
                if (rd[k] && !prev_rd[k]) begin
                    if (rises[k] == 0) first_rise[k] = cyc;
                    else if (rises[k] == 1) second_rise[k] = cyc;
                    rises[k]++;
                end
                if (vl[k] && !prev_vl[k] && first_valid[k] < 0) begin
                    first_valid[k] = cyc;
                    first_data[k]  = od[k];
                end
                if (dn[k] && done_cyc[k] < 0) done_cyc[k] = cyc;
                prev_rd[k] = rd[k];
                prev_vl[k] = vl[k];
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (first_rise[k] != 1 + sc[k]) begin errors++; $display("[TB] FAIL var%0d first_strobe: got %0d want %0d", k, first_rise[k], 1 + sc[k]); end
            checks++; if (second_rise[k] - first_rise[k] != sc[k] + ac[k] + 1) begin errors++; $display("[TB] FAIL var%0d period: got %0d want %0d", k, second_rise[k] - first_rise[k], sc[k] + ac[k] + 1); end
            checks++; if (first_valid[k] != first_rise[k] + ac[k]) begin errors++; $display("[TB] FAIL var%0d valid_rise: got %0d want %0d", k, first_valid[k], first_rise[k] + ac[k]); end
            checks++; if (first_data[k] !== model_data(15'h0100)) begin errors++; $display("[TB] FAIL var%0d first_data: got %h want %h", k, first_data[k], model_data(15'h0100)); end
            checks++; if (done_cyc[k] != 1 + 3 * (sc[k] + ac[k] + 1)) begin errors++; $display("[TB] FAIL var%0d done_cycle: got %0d want %0d", k, done_cyc[k], 1 + 3 * (sc[k] + ac[k] + 1)); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        start_addr = 15'h0;
        end_addr   = 15'h0;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_single();
        test_abort();
        test_reset_present();
        test_timing_variants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
